posit_pack_pipe: RTL



---
 rtl/posit_pkg.sv | 44 ++++
 rtl/posit_pack_pipe_if.sv | 28 ++
 rtl/posit_rne_round.sv | 26 ++
 rtl/posit_pack_pipe.sv | 122 ++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared posit definitions: decoded-field struct, special-value constants and
// the result classification used by the encoder.
package posit_pkg;

  localparam int unsigned POSIT_N  = 8;
  localparam int unsigned POSIT_ES = 4;
  localparam int unsigned POSIT_RS = $clog2(POSIT_N);

  // Decoded product fields; also consumed by the multiplier and adder front ends.
  typedef struct packed {
    logic                        sign;
    logic                        inf;
    logic                        zero;
    logic signed [POSIT_RS+2:0]  k;
    logic [POSIT_ES-1:0]         exp;
    logic [2*POSIT_N-1:0]        mant;
  } posit_fields_t;

  typedef enum logic [2:0] {
    PK_NORM,
    PK_NAR,
    PK_ZERO,
    PK_MAXPOS,
    PK_MINPOS
  } pack_kind_e;

  // Special encodings for an n-bit posit, truncate with n'(...) at the use site.
  function automatic logic [63:0] posit_nar(input int unsigned n);
    return 64'd1 << (n - 1);
  endfunction

  function automatic logic [63:0] posit_zero(input int unsigned n);
    return posit_nar(n) & ~posit_nar(n);
  endfunction

  function automatic logic [63:0] posit_maxpos(input int unsigned n);
    return posit_nar(n) - 64'd1;
  endfunction

  function automatic logic [63:0] posit_minpos(input int unsigned n);
    return posit_nar(n) >> (n - 1);
  endfunction

endpackage

// File: rtl/posit_pack_pipe_if.sv
// Valid/ready bundle between the multiplier field decode and the posit encoder.
interface posit_pack_pipe_if #(
  parameter int N  = 8,
  parameter int ES = 4,
  parameter int RS = $clog2(N)
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic                 Sign;
  logic                 inf;
  logic                 zero;
  logic signed [RS+2:0] sumR;
  logic [ES-1:0]        E_O;
  logic [2*N-1:0]       Mult_Mant_N;
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0]         posit_out;

  modport slave (
    input  in_valid, Sign, inf, zero, sumR, E_O, Mult_Mant_N, out_ready,
    output in_ready, out_valid, posit_out
  );

  modport master (
    output in_valid, Sign, inf, zero, sumR, E_O, Mult_Mant_N, out_ready,
    input  in_ready, out_valid, posit_out
  );
endinterface

// File: rtl/posit_rne_round.sv
// Regime insertion by arithmetic shift plus round-to-nearest-even of the
// posit body; bits shifted off the bottom still feed sticky.
module posit_rne_round #(
  parameter int N  = 8,
  parameter int SW = 4
) (
  input  logic [3*N-1:0] body,
  input  logic [SW-1:0]  shamt,
  output logic [N-2:0]   rounded,
  output logic           carry
);
  localparam int BW = 3*N;

  logic [BW-1:0] sh, lost_mask;
  logic          guard, sticky, lsb, up;

  always_comb begin
    sh        = $unsigned($signed(body) >>> shamt);
    lost_mask = ~({BW{1'b1}} << shamt);
    lsb       = sh[BW-N+1];
    guard     = sh[BW-N];
    sticky    = (|sh[BW-N-1:0]) | (|(body & lost_mask));
    up        = guard & (sticky | lsb);
    {carry, rounded} = {1'b0, sh[BW-1 -: N-1]} + N'(up);
  end
endmodule

// File: rtl/posit_pack_pipe.sv
// Three-stage posit encoder: S1 captures fields and builds the body, S2 rounds,
// S3 fixes up saturation/sign into the output register.
module posit_pack_pipe
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES,
  parameter int RS = $clog2(N)
) (
  input logic           clk,
  input logic           rst_n,
  posit_pack_pipe_if.slave io
);
  localparam int STAGES = 3;
  localparam int BW     = 3*N;
  localparam int PAD    = BW - 2 - ES - (2*N-1);
  localparam logic signed [RS+2:0] K_HI  = (RS+3)'(N-2);
  localparam logic signed [RS+2:0] K_LO  = (RS+3)'(-(N-1));
  localparam logic signed [RS+2:0] K_MAX = (RS+3)'(N-3);
  localparam logic signed [RS+2:0] K_MIN = (RS+3)'(-(N-2));
  localparam logic [N-2:0] MAX_BODY = (N-1)'(posit_maxpos(N));
  localparam logic [N-2:0] MIN_BODY = (N-1)'(posit_minpos(N));

  typedef struct packed {
    pack_kind_e     kind;
    logic           sign;
    logic [BW-1:0]  body;
    logic [RS:0]    shamt;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic            adv;
  posit_fields_t   in_fields, s1;
  s2_t             s2_c, s2;
  logic [N-1:0]    posit_q, res;

  // Whole pipe advances in lockstep; bubbles are not collapsed, which keeps
  // in_ready exactly equal to the advance condition.
  assign adv          = io.out_ready | ~vld_pipe[STAGES];
  assign io.in_ready  = adv;
  assign io.out_valid = vld_pipe[STAGES];
  assign io.posit_out = posit_q;

  always_comb begin
    in_fields      = '0;
    in_fields.sign = io.Sign;
    in_fields.inf  = io.inf;
    in_fields.zero = io.zero;
    in_fields.k    = io.sumR;
    in_fields.exp  = io.E_O;
    in_fields.mant = io.Mult_Mant_N;
  end

  // S1: classify, clamp k into the encodable range, lay out fill|term|exp|mant.
  logic signed [RS+2:0] k_c;
  logic [RS:0]          run;
  logic                 rfill;
  logic                 unused_hidden;

  assign unused_hidden = s1.mant[2*N-1];

  always_comb begin
    s2_c = '0;
    if (s1.inf)             s2_c.kind = PK_NAR;
    else if (s1.zero)       s2_c.kind = PK_ZERO;
    else if (s1.k >= K_HI)  s2_c.kind = PK_MAXPOS;
    else if (s1.k <= K_LO)  s2_c.kind = PK_MINPOS;
    else                    s2_c.kind = PK_NORM;
    k_c = s1.k;
    if (k_c > K_MAX)      k_c = K_MAX;
    else if (k_c < K_MIN) k_c = K_MIN;
    rfill      = ~k_c[RS+2];
    run        = rfill ? ((RS+1)'(k_c) + 1'b1) : (RS+1)'(-k_c);
    s2_c.sign  = s1.sign;
    s2_c.shamt = run - 1'b1;
    s2_c.body  = {rfill, ~rfill, s1.exp, s1.mant[2*N-2:0], {PAD{1'b0}}};
  end

  // S2: shift in the regime and round.
  logic [N-2:0] rnd;
  logic         carry;

  posit_rne_round #(.N(N), .SW(RS+1)) u_round (
    .body    (s2.body),
    .shamt   (s2.shamt),
    .rounded (rnd),
    .carry   (carry)
  );

  // S3: keep nonzero results off 0 and NaR, then apply sign and specials.
  logic [N-2:0] mag;

  always_comb begin
    case (s2.kind)
      PK_MAXPOS: mag = MAX_BODY;
      PK_MINPOS: mag = MIN_BODY;
      default: begin
        mag = rnd;
        if (carry)           mag = MAX_BODY;
        else if (rnd == '0)  mag = MIN_BODY;
      end
    endcase
    res = {1'b0, mag};
    if (s2.sign) res = -res;
    if (s2.kind == PK_NAR)       res = N'(posit_nar(N));
    else if (s2.kind == PK_ZERO) res = N'(posit_zero(N));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      posit_q  <= '0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], io.in_valid};
      s1       <= in_fields;
      s2       <= s2_c;
      posit_q  <= res;
    end
  end
endmodule
